host_run_ctrl: RTL and testbench

- Host-side counterpart to the CPU's start/halt control and its data_ram port.
- Accepts a byte stream and writes it into data_ram, then releases the CPU from start.
- Counts cycles until the CPU raises halt (or a timeout fires), then reads a window of data_ram back out as a byte stream.
- Sits beside top_level and owns the RAM port (through an external mux driven by mem_sel) whenever the CPU is not running.

---
 rtl/cpu_host_pkg.sv | 22 ++
 rtl/host_run_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_host_run_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_host_pkg.sv
// Shared definitions for the CPU / host control slice.
// Holds the RAM geometry shared with data_ram and top_level, the default run
// timeout, and the host_run_ctrl state encoding.
package cpu_host_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    localparam logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StRun,
        StRdReq,
        StRdWait,
        StOut,
        StDone
    } state_e;

endpackage

// File: rtl/host_run_ctrl.sv
// Host-side load / run / dump controller for the CPU.
// Streams bytes into data_ram, releases the CPU from start, counts RUN cycles
// until halt or timeout, then streams a window of data_ram back out.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   host_go                    start a sequence (accepted in IDLE/DONE only)
//   cfg_load_base/dump_base    first RAM address for load / dump (latched on go)
//   cfg_dump_len               dump byte count, 0..2**ADDR_W (latched on go)
//   load_valid/ready/data/last load byte stream in
//   dump_valid/ready/data/last dump byte stream out
//   cpu_start, cpu_halt        CPU control / status
//   mem_sel                    1 = controller owns the RAM port
//   mem_addr/read/write/din    RAM port driven by the controller
//   mem_dout                   RAM read data, one cycle after mem_read
//   busy, done, timeout        status flags
//   cycle_count                RUN cycles of the last run
module host_run_ctrl #(
    parameter int unsigned ADDR_W       = cpu_host_pkg::ADDR_W,
    parameter int unsigned DATA_W       = cpu_host_pkg::DATA_W,
    parameter int unsigned START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = cpu_host_pkg::TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_go,
    input  logic [ADDR_W-1:0] cfg_load_base,
    input  logic [ADDR_W-1:0] cfg_dump_base,
    input  logic [ADDR_W:0]   cfg_dump_len,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_last,
    output logic              cpu_start,
    input  logic              cpu_halt,
    output logic              mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [15:0]       cycle_count
);

    import cpu_host_pkg::*;

    localparam logic [3:0]    StartLast = 4'(START_CYCLES - 1);
    localparam logic [ADDR_W:0] IdxOne  = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   load_base_q, dump_base_q;
    logic [ADDR_W:0]     dump_len_q;
    logic [ADDR_W:0]     idx_q, idx_d;
    logic [3:0]          start_cnt_q, start_cnt_d;
    logic [15:0]         cycle_q, cycle_d;
    logic                timeout_q, timeout_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                cfg_en;

    logic [ADDR_W-1:0]   base_sel;
    logic [ADDR_W-1:0]   addr_sum;
    logic [15:0]         cycle_inc;
    logic                is_last;

    // One adder serves both phases; idx is shared between load and dump.
    assign base_sel  = (state_q == StLoad) ? load_base_q : dump_base_q;
    assign addr_sum  = base_sel + idx_q[ADDR_W-1:0];
    assign cycle_inc = cycle_q + 16'd1;
    // idx + 1 == len avoids underflow when comparing against len - 1.
    assign is_last   = ((idx_q + IdxOne) == dump_len_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            load_base_q <= '0;
            dump_base_q <= '0;
            dump_len_q  <= '0;
            idx_q       <= '0;
            start_cnt_q <= '0;
            cycle_q     <= '0;
            timeout_q   <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            start_cnt_q <= start_cnt_d;
            cycle_q     <= cycle_d;
            timeout_q   <= timeout_d;
            data_q      <= data_d;
            if (cfg_en) begin
                load_base_q <= cfg_load_base;
                dump_base_q <= cfg_dump_base;
                dump_len_q  <= cfg_dump_len;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        start_cnt_d = start_cnt_q;
        cycle_d     = cycle_q;
        timeout_d   = timeout_q;
        data_d      = data_q;
        cfg_en      = 1'b0;
        load_ready  = 1'b0;
        dump_valid  = 1'b0;
        dump_last   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        mem_din     = '0;
        mem_addr    = '0;
        cpu_start   = 1'b1;
        mem_sel     = 1'b1;
        busy        = 1'b1;
        done        = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                busy = 1'b0;
                done = (state_q == StDone);
                if (host_go) begin
                    cfg_en    = 1'b1;
                    idx_d     = '0;
                    cycle_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = StLoad;
                end
            end
            StLoad: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    mem_write = 1'b1;
                    mem_addr  = addr_sum;
                    mem_din   = load_data;
                    idx_d     = idx_q + IdxOne;
                    if (load_last) begin
                        start_cnt_d = '0;
                        state_d     = StStart;
                    end
                end
            end
            StStart: begin
                if (start_cnt_q == StartLast) begin
                    state_d = StRun;
                end else begin
                    start_cnt_d = start_cnt_q + 4'd1;
                end
            end
            StRun: begin
                cpu_start = 1'b0;
                mem_sel   = 1'b0;
                cycle_d   = cycle_inc;
                idx_d     = '0;
                // Halt has priority over a coincident timeout.
                if (cpu_halt || (cycle_inc == TIMEOUT)) begin
                    timeout_d = !cpu_halt;
                    state_d   = (dump_len_q == '0) ? StDone : StRdReq;
                end
            end
            StRdReq: begin
                mem_read = 1'b1;
                mem_addr = addr_sum;
                state_d  = StRdWait;
            end
            StRdWait: begin
                data_d  = mem_dout;
                state_d = StOut;
            end
            StOut: begin
                dump_valid = 1'b1;
                dump_last  = is_last;
                if (dump_ready) begin
                    if (is_last) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + IdxOne;
                        state_d = StRdReq;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign dump_data   = data_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_host_run_ctrl.sv
// Self-checking bench for host_run_ctrl with a RAM model, a CPU halt model and
// a dump scoreboard.
module tb_host_run_ctrl;

    localparam int unsigned START_CYC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        host_go;
    logic [7:0]  cfg_load_base, cfg_dump_base;
    logic [8:0]  cfg_dump_len;
    logic        load_valid, load_ready, load_last;
    logic [7:0]  load_data;
    logic        dump_valid, dump_ready, dump_last;
    logic [7:0]  dump_data;
    logic        cpu_start, cpu_halt, mem_sel;
    logic [7:0]  mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write;
    logic        busy, done, timeout;
    logic [15:0] cycle_count;

    always #5 clk = ~clk;

    host_run_ctrl #(
        .ADDR_W      (8),
        .DATA_W      (8),
        .START_CYCLES(START_CYC),
        .TIMEOUT     (16'd20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .host_go      (host_go),
        .cfg_load_base(cfg_load_base),
        .cfg_dump_base(cfg_dump_base),
        .cfg_dump_len (cfg_dump_len),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_data    (load_data),
        .load_last    (load_last),
        .dump_valid   (dump_valid),
        .dump_ready   (dump_ready),
        .dump_data    (dump_data),
        .dump_last    (dump_last),
        .cpu_start    (cpu_start),
        .cpu_halt     (cpu_halt),
        .mem_sel      (mem_sel),
        .mem_addr     (mem_addr),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_din      (mem_din),
        .mem_dout     (mem_dout),
        .busy         (busy),
        .done         (done),
        .timeout      (timeout),
        .cycle_count  (cycle_count)
    );

    // RAM model: only the controller side of the mux is modelled.
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (mem_sel && mem_write) ram[mem_addr] <= mem_din;
        if (mem_sel && mem_read)  mem_dout <= ram[mem_addr];
    end

    // CPU model: halt raised during RUN cycle number halt_at (0 = never).
    logic [7:0] run_cnt;
    logic [7:0] halt_at;
    always @(posedge clk) begin
        if (cpu_start) run_cnt <= 8'd0;
        else           run_cnt <= run_cnt + 8'd1;
    end
    always_comb begin
        cpu_halt = 1'b0;
        if (!cpu_start && halt_at != 8'd0 && (run_cnt + 8'd1) == halt_at) cpu_halt = 1'b1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected dump beats.
    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];

    // Ready driver: constant 1, or toggling every cycle.
    logic toggle_en = 1'b0;
    initial begin
        dump_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            dump_ready = toggle_en ? ~dump_ready : 1'b1;
        end
    end

    // Monitor: pops on each handshake, and checks stability during stalls.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        exp_t       e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                check("dump_hold_valid", 32'(dump_valid), 32'd1);
                check("dump_hold_data", 32'(dump_data), 32'(prev_data));
            end
            if (dump_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dump_unexpected: got %0h expected no beat", dump_data);
                end else begin
                    e = exp_q.pop_front();
                    check("dump_data", 32'(dump_data), 32'(e.data));
                    check("dump_last", 32'(dump_last), 32'(e.last));
                end
            end
            prev_stall = dump_valid && !dump_ready;
            prev_data  = dump_data;
        end
    end

    logic [7:0] load_q[$];

    task automatic start_seq(input logic [7:0] lb, input logic [7:0] db, input logic [8:0] dl);
        @(posedge clk);
        #1;
        cfg_load_base = lb;
        cfg_dump_base = db;
        cfg_dump_len  = dl;
        host_go       = 1'b1;
        @(posedge clk);
        #1;
        host_go = 1'b0;
        // Scrambled cfg after go must not affect the sequence.
        cfg_load_base = ~lb;
        cfg_dump_base = ~db;
        cfg_dump_len  = 9'h1AA;
        check("go_done_clr", 32'(done), 32'd0);
        check("go_busy", 32'(busy), 32'd1);
        check("go_cycles_clr", 32'(cycle_count), 32'd0);
        check("go_timeout_clr", 32'(timeout), 32'd0);
    endtask

    task automatic load_bytes();
        for (int i = 0; i < load_q.size(); i++) begin
            load_valid = 1'b1;
            load_data  = load_q[i];
            load_last  = (i == load_q.size() - 1);
            @(negedge clk);
            check("load_ready", 32'(load_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic run_phase(input int exp_cycles, input logic exp_to);
        int   sc;
        int   run_seen;
        logic mem_bad;
        sc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!cpu_start) break;
            sc++;
        end
        check("start_cycles", 32'(sc), 32'(START_CYC));
        run_seen = 1;
        mem_bad  = mem_write | mem_read | (mem_addr != 8'h00);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cpu_start) break;
            run_seen++;
            mem_bad = mem_bad | mem_write | mem_read | (mem_addr != 8'h00);
        end
        check("mem_sel_post_run", 32'(mem_sel), 32'd1);
        check("run_cycles_seen", 32'(run_seen), 32'(exp_cycles));
        check("run_mem_idle", 32'(mem_bad), 32'd0);
        check("cycle_count", 32'(cycle_count), 32'(exp_cycles));
        check("timeout", 32'(timeout), 32'(exp_to));
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check("done", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        reset         = 1'b1;
        host_go       = 1'b0;
        cfg_load_base = 8'h00;
        cfg_dump_base = 8'h00;
        cfg_dump_len  = 9'd0;
        load_valid    = 1'b0;
        load_data     = 8'h00;
        load_last     = 1'b0;
        halt_at       = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_start", 32'(cpu_start), 32'd1);
        check("rst_mem_sel", 32'(mem_sel), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_load_ready", 32'(load_ready), 32'd0);
        check("rst_dump_valid", 32'(dump_valid), 32'd0);
        check("rst_cycles", 32'(cycle_count), 32'd0);
        reset = 1'b0;

        // Reset in the middle of a load.
        start_seq(8'h40, 8'h40, 9'd1);
        load_valid = 1'b1;
        load_data  = 8'h99;
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_load_ready", 32'(load_ready), 32'd0);
        check("midrst_cpu_start", 32'(cpu_start), 32'd1);
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Wrapping load, halt on RUN cycle 10, stalled dump across the wrap.
        start_seq(8'hFE, 8'hFF, 9'd3);
        load_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        halt_at = 8'd10;
        exp_q.push_back('{data: 8'h22, last: 1'b0});
        exp_q.push_back('{data: 8'h33, last: 1'b0});
        exp_q.push_back('{data: 8'h44, last: 1'b1});
        load_bytes();
        check("ram_fe", 32'(ram[8'hFE]), 32'h11);
        check("ram_ff", 32'(ram[8'hFF]), 32'h22);
        check("ram_00", 32'(ram[8'h00]), 32'h33);
        check("ram_01", 32'(ram[8'h01]), 32'h44);
        toggle_en = 1'b1;
        run_phase(10, 1'b0);
        wait_done();
        toggle_en = 1'b0;

        // Timeout run: no halt, still dumps.
        start_seq(8'h10, 8'h10, 9'd1);
        load_q  = '{8'h5A};
        halt_at = 8'd0;
        exp_q.push_back('{data: 8'h5A, last: 1'b1});
        load_bytes();
        run_phase(20, 1'b1);
        wait_done();

        // Zero-length dump goes straight to DONE.
        start_seq(8'h20, 8'h20, 9'd0);
        load_q  = '{8'h01, 8'h02};
        halt_at = 8'd3;
        load_bytes();
        run_phase(3, 1'b0);
        wait_done();

        // New sequence from DONE with flags cleared.
        start_seq(8'h30, 8'h31, 9'd2);
        load_q  = '{8'hA1, 8'hB2, 8'hC3};
        halt_at = 8'd5;
        exp_q.push_back('{data: 8'hB2, last: 1'b0});
        exp_q.push_back('{data: 8'hC3, last: 1'b1});
        load_bytes();
        run_phase(5, 1'b0);
        wait_done();

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
